// File: rtl/sd_cmd_sequencer_if.sv
// sd_cmd_sequencer_if
// Bundles every non-clock, non-reset signal of the SD command sequencer.
//   Request side  : req_valid/req_ready handshake with req_index, req_arg, req_resp, abort
//   Transmitter   : send_en, send_cmd_content out; sd_cmd_sending back
//   Receiver      : receive_en, R2_response, R3_response out;
//                   sd_receive_started, sd_receive_finished, crc_response_err, response back
//   Completion    : done_valid, done_status, resp_data, busy
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface sd_cmd_sequencer_if;
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_index;
  logic [31:0]  req_arg;
  logic [1:0]   req_resp;
  logic         abort;
  logic         send_en;
  logic [37:0]  send_cmd_content;
  logic         sd_cmd_sending;
  logic         receive_en;
  logic         R2_response;
  logic         R3_response;
  logic         sd_receive_started;
  logic         sd_receive_finished;
  logic         crc_response_err;
  logic [126:0] response;
  logic         done_valid;
  logic [1:0]   done_status;
  logic [126:0] resp_data;
  logic         busy;

  modport slave (
    input  req_valid, req_index, req_arg, req_resp, abort,
    input  sd_cmd_sending, sd_receive_started, sd_receive_finished,
    input  crc_response_err, response,
    output req_ready, send_en, send_cmd_content, receive_en,
    output R2_response, R3_response, done_valid, done_status, resp_data, busy
  );

  modport master (
    output req_valid, req_index, req_arg, req_resp, abort,
    output sd_cmd_sending, sd_receive_started, sd_receive_finished,
    output crc_response_err, response,
    input  req_ready, send_en, send_cmd_content, receive_en,
    input  R2_response, R3_response, done_valid, done_status, resp_data, busy
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
// Sequences one SD command: accepts a request, pulses the command transmitter,
// waits for the transmitter to finish, optionally waits for and receives the
// response, retries on response timeout or CRC error, and reports completion.
// Ports:
//   ex_clk    : sole clock, rising edge
//   ex_resetn : asynchronous active-low reset
//   bus       : sd_cmd_sequencer_if.slave (request, transmitter, receiver, completion)
module sd_cmd_sequencer #(
  parameter int RESP_TIMEOUT = 64,
  parameter int MAX_RETRY    = 2
) (
  input  logic               ex_clk,
  input  logic               ex_resetn,
  sd_cmd_sequencer_if.slave  bus
);

  localparam int         CNT_W     = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [1:0] MAX_R     = 2'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, ISSUE, TX_WAIT, TX, RESP_WAIT, RX, DONE} state_t;

  state_t             state_q, state_d;
  logic [5:0]         index_q, index_d;
  logic [31:0]        arg_q, arg_d;
  logic [1:0]         resp_q, resp_d;
  logic [1:0]         retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         status_q, status_d;
  logic [126:0]       resp_data_q, resp_data_d;
  logic               rx_end;
  logic               attempt_fail;
  logic [1:0]         fail_code;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    arg_d        = arg_q;
    resp_d       = resp_q;
    retry_d      = retry_q;
    cnt_d        = '0;
    status_d     = status_q;
    resp_data_d  = resp_data_q;
    rx_end       = 1'b0;
    attempt_fail = 1'b0;
    fail_code    = 2'd0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          index_d = bus.req_index;
          arg_d   = bus.req_arg;
          resp_d  = bus.req_resp;
          retry_d = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = TX_WAIT;
      TX_WAIT: if (bus.sd_cmd_sending) state_d = TX;
      TX: begin
        if (!bus.sd_cmd_sending) begin
          if (resp_q == 2'd0) begin
            state_d  = DONE;
            status_d = 2'd0;
          end else begin
            state_d = RESP_WAIT;
          end
        end
      end
      RESP_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response that starts and finishes in the same cycle skips RX.
        if (bus.sd_receive_started && bus.sd_receive_finished) begin
          rx_end = 1'b1;
        end else if (bus.sd_receive_started) begin
          state_d = RX;
        end else if (cnt_q == CNT_LAST) begin
          attempt_fail = 1'b1;
          fail_code    = 2'd1;
        end
      end
      RX:      if (bus.sd_receive_finished) rx_end = 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rx_end) begin
      resp_data_d = bus.response;
      // R3 carries no valid CRC, so its CRC flag is ignored.
      if (bus.crc_response_err && (resp_q != 2'd3)) begin
        attempt_fail = 1'b1;
        fail_code    = 2'd2;
      end else begin
        state_d  = DONE;
        status_d = 2'd0;
      end
    end

    if (attempt_fail) begin
      if (retry_q < MAX_R) begin
        retry_d = retry_q + 2'd1;
        state_d = ISSUE;
      end else begin
        state_d  = DONE;
        status_d = fail_code;
      end
    end

    // Abort wins over everything in an active state; the transaction result is discarded.
    if (bus.abort && (state_q != IDLE) && (state_q != DONE)) begin
      state_d     = DONE;
      status_d    = 2'd3;
      resp_data_d = resp_data_q;
      retry_d     = retry_q;
    end
  end

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      state_q     <= IDLE;
      index_q     <= '0;
      arg_q       <= '0;
      resp_q      <= '0;
      retry_q     <= '0;
      cnt_q       <= '0;
      status_q    <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      arg_q       <= arg_d;
      resp_q      <= resp_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      status_q    <= status_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign bus.req_ready        = (state_q == IDLE);
  assign bus.busy             = (state_q != IDLE);
  assign bus.send_en          = (state_q == ISSUE);
  assign bus.send_cmd_content = {index_q, arg_q};
  assign bus.receive_en       = (state_q == RESP_WAIT) || (state_q == RX);
  assign bus.R2_response      = bus.receive_en && (resp_q == 2'd2);
  assign bus.R3_response      = bus.receive_en && (resp_q == 2'd3);
  assign bus.done_valid       = (state_q == DONE);
  assign bus.done_status      = status_q;
  assign bus.resp_data        = resp_data_q;

endmodule

// File: doc/sd_cmd_sequencer.md
SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 64: ex_clk cycles allowed in RESP_WAIT before timeout.
REQ-002 SHALL have parameter MAX_RETRY, default 2: re-issues allowed after timeout or CRC error (range 0-3).
REQ-003 SHALL have port ex_clk in 1: sole clock; all state on its rising edge.
REQ-004 SHALL have port ex_resetn in 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid in 1: command request.
REQ-006 SHALL have port req_ready out 1: sequencer accepts a request.
REQ-007 SHALL have port req_index in 6: command index.
REQ-008 SHALL have port req_arg in 32: command argument.
REQ-009 SHALL have port req_resp in 2: response type; 0 none, 1 R1, 2 R2, 3 R3.
REQ-010 SHALL have port abort in 1: software abort.
REQ-011 SHALL have port send_en out 1: start pulse to command transmitter.
REQ-012 SHALL have port send_cmd_content out 38: {index, arg}.
REQ-013 SHALL have port sd_cmd_sending in 1: transmitter busy.
REQ-014 SHALL have port receive_en out 1: response receiver enable.
REQ-015 SHALL have port R2_response out 1: 136-bit response expected.
REQ-016 SHALL have port R3_response out 1: CRC-less response expected.
REQ-017 SHALL have port sd_receive_started in 1: response start bit seen.
REQ-018 SHALL have port sd_receive_finished in 1: response complete.
REQ-019 SHALL have port crc_response_err in 1: CRC mismatch, valid with finished.
REQ-020 SHALL have port response in 127: received response payload.
REQ-021 SHALL have port done_valid out 1: one-cycle completion pulse.
REQ-022 SHALL have port done_status out 2: 0 OK, 1 timeout, 2 CRC error, 3 aborted.
REQ-023 SHALL have port resp_data out 127: latched response.
REQ-024 SHALL have port busy out 1: high in every state except IDLE.

Function
REQ-025 SHALL implement FSM states IDLE, ISSUE, TX_WAIT, TX, RESP_WAIT, RX, DONE.
REQ-026 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid&req_ready, capturing index/arg/resp, clearing retry count, and moving to ISSUE.
REQ-027 SHALL assert send_en for exactly one cycle in ISSUE, with send_cmd_content stable from ISSUE until DONE, then move to TX_WAIT.
REQ-028 SHALL leave TX_WAIT for TX when sd_cmd_sending=1, and TX for post-transmit when sd_cmd_sending=0.
REQ-029 SHALL, post-transmit, go to DONE with status 0 if resp=0; otherwise go to RESP_WAIT with timeout counter cleared.
REQ-030 SHALL hold receive_en=1 in RESP_WAIT and RX; R2_response=(resp==2) and R3_response=(resp==3) in those states; all three are 0 elsewhere.
REQ-031 SHALL, in RESP_WAIT, increment the counter each cycle; sd_receive_started moves to RX; counter reaching RESP_TIMEOUT-1 without started constitutes a timeout.
REQ-032 SHALL give sd_receive_started priority over timeout in the same cycle; started together with finished SHALL be handled as finished.
REQ-033 SHALL, in RX, on sd_receive_finished latch response into resp_data; a CRC error is crc_response_err=1 and resp!=3 (R3 ignores CRC).
REQ-034 SHALL, on timeout or CRC error with retry count < MAX_RETRY, increment retry count and return to ISSUE; otherwise go to DONE with status 1 (timeout) or 2 (CRC).
REQ-035 SHALL, in RX with no CRC error, go to DONE with status 0.
REQ-036 SHALL pulse done_valid for one cycle in DONE, hold done_status and resp_data until the next DONE, then return to IDLE.
REQ-037 SHALL, on abort in any state except IDLE/DONE, go to DONE with status 3, dropping send_en/receive_en the next cycle; abort in IDLE is ignored.
REQ-038 SHALL apply no timeout in TX_WAIT/TX; the transmitter is trusted to complete.

Reset
REQ-039 SHALL, on ex_resetn=0, asynchronously enter IDLE; req_ready=1 after reset; send_en, receive_en, R2/R3_response, done_valid, busy=0; done_status=0; resp_data=0; send_cmd_content=0; counters=0.
REQ-040 SHALL abandon any transaction when reset is asserted mid-operation, producing no done_valid.

Verification
REQ-041 CMD0 (index 0, arg 0, resp 0) -> one send_en pulse, content 38'h0; after sending falls, done_valid, status 0.
REQ-042 CMD8 resp 1, started 5 cycles after TX, finished, crc=0 -> resp_data=response, status 0, receive_en low after DONE.
REQ-043 resp 1, no started -> 3 send_en pulses (MAX_RETRY=2), each RESP_WAIT 64 cycles, then status 1.
REQ-044 ACMD41 resp 3 with crc_response_err=1 -> status 0, no retry; resp 2 with CRC error on first try only -> 2 send_en pulses, status 0.
REQ-045 Abort during RESP_WAIT -> next cycle DONE, status 3, receive_en=0; ex_resetn low during TX -> IDLE, no done_valid.
REQ-046 Started on the timeout cycle -> RX entered, no retry; req_valid held during busy -> not accepted until IDLE.
